mem2reg_scan_reader: RTL and testbench
======================================

Name: mem2reg_scan_reader

Overview:
- Register-file block: storage is a flattened register array (mem2reg attribute), written through a single write port.
- A sequential read-out engine sweeps every entry in ascending address order and streams it out over a valid/ready handshake.
- It is the reader counterpart of the clocked writer blocks in the mem2reg test set, and exercises memory-to-register conversion on the read side under backpressure.

Parameters:
- WIDTH, 4, data bits per entry
- DEPTH, 8, number of entries; must satisfy DEPTH <= 2**ADDR_W
- ADDR_W, 3, address bits for waddr and out_addr

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- start  input  1  request a full sweep; honoured only in IDLE
- out_ready  input  1  consumer ready
- out_valid  output  1  out_data/out_addr hold a valid entry
- out_addr  output  ADDR_W  address of presented entry
- out_data  output  WIDTH  data of presented entry
- out_last  output  1  presented entry is address DEPTH-1
- busy  output  1  engine in SCAN state
- done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (reset==0 at an edge):
  - mem[i] <= i truncated to WIDTH, for every i.
  - State IDLE; out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0.
  - Reset overrides everything, including a write or a sweep in progress; no done pulse is produced.
- Write port:
  - When we=1 and waddr<DEPTH, mem[waddr] <= wdata at the edge.
  - When waddr>=DEPTH, the write is ignored.
  - Writes are accepted in every state.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - start=1 -> next cycle state SCAN, out_valid=1, out_addr=0, out_data=mem[0], busy=1. Latency is 1 cycle.
  - out_last=1 on that cycle only if DEPTH==1.
- SCAN:
  - A handshake occurs on a cycle with out_valid & out_ready.
  - Handshake with out_addr<DEPTH-1 -> next cycle out_addr+1 and out_data=mem[out_addr+1]. There is no bubble, so full throughput is 1 entry/cycle.
  - Handshake with out_addr==DEPTH-1 -> next cycle out_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
  - No handshake -> out_valid, out_addr, out_data and out_last hold stable.
- start while in SCAN is ignored. start on the cycle done is high is accepted, since the state is already IDLE.
- out_data is captured at load time. A write to the currently presented address does not change the held out_data.
- A write to an address not yet presented is visible when that address is loaded.
- Simultaneous write and load of the same address: the load returns the pre-write value (read-before-write).
- out_last = out_valid && (out_addr == DEPTH-1).
- Address counter arithmetic is ADDR_W bits wide. The counter never advances past DEPTH-1, so it has no wrap-around.
- Outputs are registered; there is no combinational path from out_ready to out_valid, out_data or out_addr.

Test Plan:
1. Reset default dump:
   - Stimulus: reset low 2 cycles, start for 1 cycle, out_ready tied 1.
   - Required: out_data 0,1,...,7 on consecutive cycles at out_addr 0..7; out_last only at addr 7; done pulses the cycle after addr 7; busy high for exactly 8 cycles.
2. Write then dump:
   - Stimulus: write mem[2]=4'hA and mem[5]=4'h3, then start, out_ready=1.
   - Required: stream is 0,1,A,3,4,3,6,7.
3. Backpressure:
   - Stimulus: out_ready toggles 1,0,0,1,... during a sweep.
   - Required: out_addr/out_data are stable whenever out_ready=0; all 8 entries are delivered exactly once, in order; no duplicates.
4. Write collision:
   - Stimulus: while entry 3 is presented and stalled, write mem[3]=4'hF; also write mem[6]=4'hC before addr 6 is reached.
   - Required: presented data stays 3; addr 6 emits C.
   - Additionally: a write to mem[4] on the same cycle as the handshake at addr 3 -> addr 4 emits the old value.
5. Start/reset edge cases:
   - start pulsed mid-SCAN -> ignored, and exactly one done pulse results.
   - start on the done cycle -> a second sweep starts immediately.
   - reset low at addr 4 -> out_valid=0 next cycle, no done pulse, mem restored to 0..7.
6. Out-of-range write:
   - Stimulus: DEPTH=6, ADDR_W=3; we=1 with waddr=7, wdata=F; then sweep.
   - Required: stream is 0..5 unchanged; out_last at addr 5.

Source files
------------

// File: rtl/mem2reg_scan_reader_if.sv
// rtl/mem2reg_scan_reader_if.sv - write port, sweep control and read-out stream bundle
interface mem2reg_scan_reader_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              start;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output we, waddr, wdata, start, out_ready,
    input  out_valid, out_addr, out_data, out_last, busy, done
  );

  modport slave (
    input  we, waddr, wdata, start, out_ready,
    output out_valid, out_addr, out_data, out_last, busy, done
  );
endinterface

// File: rtl/mem2reg_scan_reader.sv
// rtl/mem2reg_scan_reader.sv - register file with an in-order valid/ready sweep reader
module mem2reg_scan_reader #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic                    clk,
  input logic                    reset,
  mem2reg_scan_reader_if.slave   bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  (* mem2reg *) logic [WIDTH-1:0] mem [DEPTH];

  state_t            state;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  data_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] addr_nxt;
  assign addr_nxt = addr_q + 1'b1;

  // Loads below read mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
      state   <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.we && (32'(bus.waddr) < DEPTH)) mem[bus.waddr] <= bus.wdata;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SCAN;
            valid_q <= 1'b1;
            addr_q  <= '0;
            data_q  <= mem[0];
            last_q  <= (LAST == '0);
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (valid_q && bus.out_ready) begin
            if (addr_q == LAST) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_nxt;
              data_q <= mem[addr_nxt];
              last_q <= (addr_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem2reg_scan_reader.sv
// tb/tb_mem2reg_scan_reader.sv - randomized and directed bench with a stream-level reference model
module tb_mem2reg_scan_reader;

  localparam int W = 4;
  localparam int A = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         we = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [W-1:0] wdata = '0;
  logic         start = 1'b0;
  logic         out_ready = 1'b1;

  mem2reg_scan_reader_if #(.WIDTH(W), .ADDR_W(A)) b8 ();
  mem2reg_scan_reader_if #(.WIDTH(W), .ADDR_W(A)) b6 ();

  assign b8.we = we;  assign b8.waddr = waddr;  assign b8.wdata = wdata;
  assign b8.start = start;  assign b8.out_ready = out_ready;
  assign b6.we = we;  assign b6.waddr = waddr;  assign b6.wdata = wdata;
  assign b6.start = start;  assign b6.out_ready = out_ready;

  mem2reg_scan_reader #(.WIDTH(W), .DEPTH(8), .ADDR_W(A)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  mem2reg_scan_reader #(.WIDTH(W), .DEPTH(6), .ADDR_W(A)) dut6 (.clk(clk), .reset(reset), .bus(b6));

  // Reference: memory contents plus "which entry is on offer and what was captured".
  int           dep [2] = '{8, 6};
  logic [W-1:0] mm [2][8];
  bit           mv [2];
  bit           mdone [2];
  bit           mchk [2];
  int           ma [2];
  logic [W-1:0] md [2];

  int ncmp = 0;
  int nbad = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int exp_s[$];
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_step(int k);
    if (!reset) begin
      for (int i = 0; i < 8; i++) mm[k][i] = W'(i);
      mv[k] = 0; mdone[k] = 0; mchk[k] = 1; ma[k] = 0; md[k] = '0;
      return;
    end
    mdone[k] = 0;
    mchk[k] = 0;
    if (mv[k]) begin
      if (out_ready) begin
        if (ma[k] == dep[k] - 1) begin
          mv[k] = 0;
          mdone[k] = 1;
        end else begin
          ma[k] = ma[k] + 1;
          md[k] = mm[k][ma[k]];
        end
      end
    end else if (start) begin
      mv[k] = 1; ma[k] = 0; md[k] = mm[k][0];
    end
    if (mv[k]) mchk[k] = 1;
    if (we && int'(waddr) < dep[k]) mm[k][waddr] = wdata;
  endfunction

  task automatic cmp_dut(int k, logic v, logic [A-1:0] a, logic [W-1:0] d,
                         logic l, logic b, logic dn);
    check($sformatf("d%0d_valid", k), v, mv[k]);
    check($sformatf("d%0d_busy", k), b, mv[k]);
    check($sformatf("d%0d_done", k), dn, mdone[k]);
    check($sformatf("d%0d_last", k), l, mv[k] && ma[k] == dep[k] - 1);
    if (mchk[k]) begin
      check($sformatf("d%0d_addr", k), a, ma[k]);
      check($sformatf("d%0d_data", k), d, md[k]);
    end
  endtask

  task automatic tick();
    if (b8.out_valid === 1'b1 && out_ready) q0.push_back(b8.out_data);
    if (b6.out_valid === 1'b1 && out_ready) q1.push_back(b6.out_data);
    if (b8.busy === 1'b1) busy_cnt++;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    if (b8.done === 1'b1) done_cnt++;
    cmp_dut(0, b8.out_valid, b8.out_addr, b8.out_data, b8.out_last, b8.busy, b8.done);
    cmp_dut(1, b6.out_valid, b6.out_addr, b6.out_data, b6.out_last, b6.busy, b6.done);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic sweep_wait(string tag);
    int n = 0;
    while (!mdone[0] && n < 60) begin
      tick();
      n++;
    end
    if (!mdone[0]) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_stream(string tag, int k);
    int n = (k == 0) ? q0.size() : q1.size();
    check({tag, "_len"}, n, exp_s.size());
    for (int i = 0; i < exp_s.size() && i < n; i++)
      check($sformatf("%s_%0d", tag, i), (k == 0) ? q0[i] : q1[i], exp_s[i]);
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    run(n);
    reset = 1'b1;
  endtask

  initial begin
    // Reset default dump
    do_reset(2);
    q0.delete(); busy_cnt = 0; done_cnt = 0;
    pulse_start();
    sweep_wait("t1");
    tick();
    exp_s = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_stream("t1_stream", 0);
    check("t1_busy_cycles", busy_cnt, 8);
    check("t1_done_count", done_cnt, 1);

    // Write then dump
    we = 1'b1; waddr = 3'd2; wdata = 4'hA; tick();
    waddr = 3'd5; wdata = 4'h3; tick();
    we = 1'b0;
    q0.delete();
    pulse_start();
    sweep_wait("t2");
    exp_s = '{0, 1, 10, 3, 4, 3, 6, 7};
    check_stream("t2_stream", 0);

    // Backpressure 1,0,0,...
    q0.delete();
    pulse_start();
    for (int c = 0; c < 60 && !mdone[0]; c++) begin
      out_ready = (c % 3 == 0);
      tick();
    end
    out_ready = 1'b1;
    check_stream("t3_stream", 0);

    // Write collision while stalled, and same-cycle write at handshake
    do_reset(1);
    q0.delete();
    pulse_start();
    run(3);
    out_ready = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 4'hF; tick();
    waddr = 3'd6; wdata = 4'hC; tick();
    we = 1'b0; tick();
    check("t4_held_data", b8.out_data, 3);
    out_ready = 1'b1;
    we = 1'b1; waddr = 3'd4; wdata = 4'h9; tick();
    we = 1'b0;
    check("t4_old_addr4", b8.out_data, 4);
    sweep_wait("t4");
    exp_s = '{0, 1, 2, 3, 4, 5, 12, 7};
    check_stream("t4_stream", 0);

    // start mid-SCAN ignored
    done_cnt = 0;
    pulse_start();
    run(3);
    pulse_start();
    sweep_wait("t5a");
    run(3);
    check("t5_single_done", done_cnt, 1);

    // start on the done cycle
    pulse_start();
    sweep_wait("t5b");
    check("t5_done_seen", b8.done, 1);
    pulse_start();
    check("t5_restart_valid", b8.out_valid, 1);
    check("t5_restart_addr", b8.out_addr, 0);
    sweep_wait("t5b2");

    // reset mid-sweep at addr 4
    done_cnt = 0;
    pulse_start();
    run(4);
    check("t5_at_addr4", b8.out_addr, 4);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t5_rst_valid", b8.out_valid, 0);
    run(2);
    check("t5_rst_no_done", done_cnt, 0);
    q0.delete();
    pulse_start();
    sweep_wait("t5c");
    exp_s = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_stream("t5_rst_stream", 0);

    // Out-of-range write on the 6-deep instance
    do_reset(1);
    we = 1'b1; waddr = 3'd7; wdata = 4'hF; tick();
    we = 1'b0;
    q1.delete();
    pulse_start();
    sweep_wait("t6");
    exp_s = '{0, 1, 2, 3, 4, 5};
    check_stream("t6_stream", 1);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      we = 1'($urandom_range(0, 1));
      waddr = A'($urandom_range(0, 7));
      wdata = W'($urandom);
      start = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 79) != 0);
      tick();
    end
    reset = 1'b1; we = 1'b0; start = 1'b0; out_ready = 1'b1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
